// File: rtl/demux32_1to4_buf.sv
`default_nettype none
// ============================================================================
// Module  : demux32_1to4_buf
// Brief   : Buffered 1-to-4 demultiplexer with a one-entry holding register
//           and per-channel wrapping accept counters.
// Revision: 1.0
// ============================================================================
module demux32_1to4_buf #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [1:0]         select,
  input  logic [WIDTH-1:0]   in_data,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [WIDTH-1:0]   outA,
  output logic [WIDTH-1:0]   outB,
  output logic [WIDTH-1:0]   outC,
  output logic [WIDTH-1:0]   outD,
  output logic [3:0]         out_valid,
  input  logic [3:0]         out_ready,
  output logic [4*CNT_W-1:0] xfer_cnt
);

  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_FULL  = 1'b1;

  logic             w_acc;
  logic [3:0]       w_load;
  logic [3:0]       w_drain;
  logic [WIDTH-1:0] w_hold [4];

  // Readiness looks only at the addressed channel so the source may retarget freely.
  assign in_ready = ~out_valid[select] | out_ready[select];
  assign w_acc    = in_valid & in_ready;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_ch
      logic [0:0]       r_state;
      logic [WIDTH-1:0] r_hold;
      logic [CNT_W-1:0] r_cnt;

      assign w_load[gi]  = w_acc & (select == 2'(gi));
      assign w_drain[gi] = (r_state == ST_FULL) & out_ready[gi];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_state <= ST_EMPTY;
          r_hold  <= '0;
          r_cnt   <= '0;
        end else begin
          if (w_load[gi]) begin
            r_state <= ST_FULL;
            r_hold  <= in_data;
            r_cnt   <= r_cnt + CNT_W'(1);
          end else if (w_drain[gi]) begin
            // Data is kept on drain; only the valid flag drops.
            r_state <= ST_EMPTY;
          end
        end
      end

      assign out_valid[gi]                = (r_state == ST_FULL);
      assign w_hold[gi]                   = r_hold;
      assign xfer_cnt[gi*CNT_W +: CNT_W]  = r_cnt;
    end
  endgenerate

  assign outA = w_hold[0];
  assign outB = w_hold[1];
  assign outC = w_hold[2];
  assign outD = w_hold[3];

endmodule
`default_nettype wire

// File: tb/tb_demux32_1to4_buf.sv
`default_nettype none
// ============================================================================
// Module  : tb_demux32_1to4_buf
// Brief   : Scoreboard bench for demux32_1to4_buf with directed and random traffic.
// Revision: 1.0
// ============================================================================
module tb_demux32_1to4_buf;

  localparam int WIDTH = 32;
  localparam int CNT_W = 8;

  logic               clk;
  logic               rst_n;
  logic [1:0]         select;
  logic [WIDTH-1:0]   in_data;
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   outA, outB, outC, outD;
  logic [3:0]         out_valid;
  logic [3:0]         out_ready;
  logic [4*CNT_W-1:0] xfer_cnt;

  int checks = 0;
  int errors = 0;

  demux32_1to4_buf #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .select    (select),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .outA      (outA),
    .outB      (outB),
    .outC      (outC),
    .outD      (outD),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .xfer_cnt  (xfer_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [WIDTH-1:0] dout [4];
  always_comb begin
    dout[0] = outA;
    dout[1] = outB;
    dout[2] = outC;
    dout[3] = outD;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: per-channel FIFO of undelivered words, last word shown, and count.
  logic [WIDTH-1:0] chq [4][$];
  logic [WIDTH-1:0] shown [4];
  int               mcnt [4];
  int               n_acc = 0;
  int               n_del = 0;
  int               n_drop = 0;

  always @(negedge clk) begin
    logic m_rdy;
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        n_drop += chq[i].size();
        chq[i].delete();
        shown[i] = '0;
        mcnt[i]  = 0;
      end
    end
    for (int i = 0; i < 4; i++) begin
      check($sformatf("out_valid[%0d]", i), 64'(out_valid[i]), 64'(chq[i].size() != 0));
      check($sformatf("out_data[%0d]", i), 64'(dout[i]), 64'(shown[i]));
      check($sformatf("cnt[%0d]", i), 64'(xfer_cnt[i*CNT_W +: CNT_W]), 64'(mcnt[i] % 256));
    end
    m_rdy = (chq[select].size() == 0) || out_ready[select];
    check("in_ready", 64'(in_ready), 64'(m_rdy));
    if (rst_n) begin
      for (int i = 0; i < 4; i++) begin
        if (chq[i].size() != 0 && out_ready[i]) begin
          check($sformatf("deliver[%0d]", i), 64'(dout[i]), 64'(chq[i][0]));
          void'(chq[i].pop_front());
          n_del++;
        end
      end
      if (in_valid && m_rdy) begin
        chq[select].push_back(in_data);
        shown[select] = in_data;
        mcnt[select]  = (mcnt[select] + 1) % 256;
        n_acc++;
      end
    end
  end

  task automatic step(input logic v, input logic [1:0] sel, input logic [WIDTH-1:0] d,
                      input logic [3:0] rdy);
    @(posedge clk);
    #1;
    in_valid  = v;
    select    = sel;
    in_data   = d;
    out_ready = rdy;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; select = 2'd0; in_data = '0; out_ready = 4'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Single word to C, held while consumer stalls
    step(1'b1, 2'd2, 32'hDEADBEEF, 4'b0000);
    step(1'b0, 2'd2, 32'h0, 4'b0000);
    #1;
    check("t2_valid", 64'(out_valid), 64'h4);
    check("t2_outC", 64'(outC), 64'hDEADBEEF);
    check("t2_cntC", 64'(xfer_cnt[23:16]), 64'd1);
    check("t2_in_ready", 64'(in_ready), 64'd0);

    // Drain and reload C in the same cycle
    step(1'b1, 2'd2, 32'h12345678, 4'b0100);
    #1 check("t3_in_ready", 64'(in_ready), 64'd1);
    step(1'b0, 2'd2, 32'h0, 4'b0000);
    #1;
    check("t3_outC", 64'(outC), 64'h12345678);
    check("t3_valid", 64'(out_valid), 64'h4);
    check("t3_cntC", 64'(xfer_cnt[23:16]), 64'd2);
    step(1'b0, 2'd0, 32'h0, 4'b0100);
    step(1'b0, 2'd0, 32'h0, 4'b0000);
    #1 check("t3_drained", 64'(out_valid), 64'h0);
    check("t3_retain", 64'(outC), 64'h12345678);

    // Back-to-back A..D, then a stalled fifth word to B
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 2'(i), 32'hA0000000 + 32'(i), 4'b0000);
      #1 check("t4_acc", 64'(in_ready), 64'd1);
    end
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 2'd1, 32'hBBBB0005, 4'b0000);
      #1 check("t4_stall", 64'(in_ready), 64'd0);
    end
    check("t4_all_full", 64'(out_valid), 64'hF);
    step(1'b1, 2'd1, 32'hBBBB0005, 4'b0010);
    #1 check("t4_unstall", 64'(in_ready), 64'd1);
    step(1'b0, 2'd1, 32'h0, 4'b0000);
    #1 check("t4_outB", 64'(outB), 64'hBBBB0005);
    check("t4_valid", 64'(out_valid), 64'hF);

    // Asynchronous reset in the middle of a cycle
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("rst_valid", 64'(out_valid), 64'h0);
    check("rst_cnt", 64'(xfer_cnt), 64'h0);
    check("rst_outs", 64'(outA | outB | outC | outD), 64'h0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Counter wrap on D, other counts untouched
    step(1'b1, 2'd0, 32'h00000AAA, 4'b0000);
    for (int i = 0; i < 256; i++) begin
      step(1'b1, 2'd3, 32'(i), 4'b1000);
      if (i == 255) begin
        #1 check("t5_cntD_255", 64'(xfer_cnt[31:24]), 64'd255);
      end
    end
    step(1'b0, 2'd0, 32'h0, 4'b1000);
    #1;
    check("t5_cntD_wrap", 64'(xfer_cnt[31:24]), 64'd0);
    check("t5_cntA", 64'(xfer_cnt[7:0]), 64'd1);
    check("t5_cntBC", 64'(xfer_cnt[23:8]), 64'd0);

    // Random traffic
    for (int n = 0; n < 10000; n++) begin
      step(($urandom_range(0, 9) < 7), 2'($urandom_range(0, 3)), $urandom,
           4'($urandom_range(0, 15)));
    end
    for (int n = 0; n < 4; n++) step(1'b0, 2'd0, 32'h0, 4'b1111);
    @(negedge clk);
    @(negedge clk);
    check("all_drained", 64'(out_valid), 64'h0);
    check("delivered_once", 64'(n_del + n_drop), 64'(n_acc));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
